// File: rtl/if_prefetch_buf_pkg.sv
// Shared definitions for the instruction-fetch prefetch queue.
//   XLEN_DEF     default data/address width
//   NOP_INSN     canonical RV32 nop (addi x0,x0,0)
//   IF_RESET_PC  default fetch address after reset
//   FLD_*        field slot indices of a queue entry {pc, pc4, ir}, in units of XLEN
package if_prefetch_buf_pkg;

  localparam int unsigned XLEN_DEF    = 32;
  localparam logic [31:0] NOP_INSN    = 32'h0000_0013;
  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

  localparam int unsigned FLD_IR     = 0;
  localparam int unsigned FLD_PC4    = 1;
  localparam int unsigned FLD_PC     = 2;
  localparam int unsigned NUM_FIELDS = 3;

endpackage

// File: rtl/if_prefetch_buf_queue_ram.sv
// Storage array for the prefetch queue.
//   clk    clock
//   we     write enable; wdata is stored at waddr on the rising edge
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  combinational read data
// The array has no reset; contents are only meaningful where the
// controller has written them.
module if_queue_ram
  import if_prefetch_buf_pkg::*;
#(
  parameter int unsigned WIDTH = NUM_FIELDS * XLEN_DEF,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_prefetch_buf.sv
// Instruction-fetch queue between instruction memory and the IF/ID registers.
// Issues sequential fetch addresses on iad, accepts a word whenever acki_n is
// low and buffers up to DEPTH {pc, pc4, ir} entries so fetch keeps running
// while decode stalls. A redirect from EX flushes the queue and restarts
// fetch at redirect_pc.
//   clk          clock
//   rst_n        synchronous active-low reset
//   iad          fetch address to instruction memory
//   idt          instruction word from memory
//   acki_n       0: idt is valid for iad this cycle
//   redirect     taken jump/branch from EX
//   redirect_pc  jump target
//   deq_ready    decode consumes the head entry this cycle
//   out_valid    head entry valid
//   out_pc       pc of head entry (0 when empty)
//   out_pc4      pc+4 of head entry (0 when empty)
//   out_ir       instruction of head entry (0 when empty)
//   count        number of occupied entries
module if_prefetch_buf
  import if_prefetch_buf_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IF_RESET_PC)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic [XLEN-1:0]            iad,
  input  logic [XLEN-1:0]            idt,
  input  logic                       acki_n,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  input  logic                       deq_ready,
  output logic                       out_valid,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_pc4,
  output logic [XLEN-1:0]            out_ir,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned EW = NUM_FIELDS * XLEN;

  logic [XLEN-1:0] fpc;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            enq;
  logic            deq;
  logic [EW-1:0]   wdata;
  logic [EW-1:0]   rdata;

  assign iad       = fpc;
  assign out_valid = (count != '0);
  assign deq       = deq_ready & out_valid;
  // A full queue still accepts a word when the head leaves in the same cycle.
  assign enq       = ~acki_n & ~redirect & ((count < CW'(DEPTH)) | deq);

  always_comb begin
    wdata                         = '0;
    wdata[FLD_PC  * XLEN +: XLEN] = fpc;
    wdata[FLD_PC4 * XLEN +: XLEN] = fpc + XLEN'(4);
    wdata[FLD_IR  * XLEN +: XLEN] = idt;
  end

  if_queue_ram #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (enq),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fpc    <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      // Flush wins over any enqueue/dequeue in the same cycle.
      fpc    <= redirect_pc;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + AW'(1);
        fpc    <= fpc + XLEN'(4);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (enq && !deq) begin
        count <= count + CW'(1);
      end else if (deq && !enq) begin
        count <= count - CW'(1);
      end
    end
  end

  // Empty queue presents zeros rather than stale storage.
  assign out_pc  = out_valid ? rdata[FLD_PC  * XLEN +: XLEN] : '0;
  assign out_pc4 = out_valid ? rdata[FLD_PC4 * XLEN +: XLEN] : '0;
  assign out_ir  = out_valid ? rdata[FLD_IR  * XLEN +: XLEN] : '0;

endmodule

// File: tb/tb_if_prefetch_buf.sv
// Bench for if_prefetch_buf: two instances (DEPTH 4 and DEPTH 8) share one
// stimulus stream. Each has a queue-of-entries reference model; a monitor
// pops and compares whenever an instance dequeues.
module tb_if_prefetch_buf;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int unsigned NI  = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n, acki_n, redirect, deq_ready;
  logic [31:0] idt, redirect_pc;

  logic [31:0] d_iad [NI];
  logic [31:0] d_pc  [NI];
  logic [31:0] d_pc4 [NI];
  logic [31:0] d_ir  [NI];
  logic        d_ov  [NI];
  logic [2:0]  cnt0;
  logic [3:0]  cnt1;
  int unsigned d_cnt [NI];

  assign d_cnt[0] = 32'(cnt0);
  assign d_cnt[1] = 32'(cnt1);

  always #5 clk = ~clk;

  if_prefetch_buf #(.XLEN(32), .DEPTH(4), .RESET_PC(RPC)) dut4 (
    .clk(clk), .rst_n(rst_n), .iad(d_iad[0]), .idt(idt), .acki_n(acki_n),
    .redirect(redirect), .redirect_pc(redirect_pc), .deq_ready(deq_ready),
    .out_valid(d_ov[0]), .out_pc(d_pc[0]), .out_pc4(d_pc4[0]), .out_ir(d_ir[0]),
    .count(cnt0)
  );

  if_prefetch_buf #(.XLEN(32), .DEPTH(8), .RESET_PC(RPC)) dut8 (
    .clk(clk), .rst_n(rst_n), .iad(d_iad[1]), .idt(idt), .acki_n(acki_n),
    .redirect(redirect), .redirect_pc(redirect_pc), .deq_ready(deq_ready),
    .out_valid(d_ov[1]), .out_pc(d_pc[1]), .out_pc4(d_pc4[1]), .out_ir(d_ir[1]),
    .count(cnt1)
  );

  // Reference model state
  ent_t        q [NI][$];
  logic [31:0] mfpc [NI];
  int unsigned mdepth [NI] = '{4, 8};
  bit          armed = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int unsigned k,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Monitor: whenever an instance dequeues, its head must match the model.
  always @(negedge clk) begin
    #1;
    if (armed && rst_n && !redirect && deq_ready) begin
      for (int unsigned k = 0; k < NI; k++) begin
        if (d_ov[k]) begin
          if (q[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL deq_underflow dut%0d: got dequeue expected none at %0t", k, $time);
          end else begin
            ent_t e;
            e = q[k].pop_front();
            chk("deq_pc", k, d_pc[k], e.pc);
            chk("deq_pc4", k, d_pc4[k], e.pc + 32'd4);
            chk("deq_ir", k, d_ir[k], e.ir);
          end
        end
      end
    end
  end

  task automatic check_state();
    for (int unsigned k = 0; k < NI; k++) begin
      chk("iad", k, d_iad[k], mfpc[k]);
      chk("count", k, d_cnt[k], q[k].size());
      chk("out_valid", k, 32'(d_ov[k]), 32'(q[k].size() != 0));
      if (q[k].size() == 0) begin
        chk("empty_pc", k, d_pc[k], 32'h0);
        chk("empty_pc4", k, d_pc4[k], 32'h0);
        chk("empty_ir", k, d_ir[k], 32'h0);
      end else begin
        chk("head_pc", k, d_pc[k], q[k][0].pc);
      end
    end
  endtask

  // One clock: check post-edge state, drive inputs, then advance the model.
  task automatic step(input logic rn, input logic ack, input logic dr,
                      input logic rd, input logic [31:0] rpc, input logic [31:0] wd);
    bit enqm [NI];
    @(negedge clk);
    if (armed) check_state();
    rst_n       = rn;
    acki_n      = ack;
    deq_ready   = dr;
    redirect    = rd;
    redirect_pc = rpc;
    idt         = wd;
    for (int unsigned k = 0; k < NI; k++) begin
      int unsigned sz;
      sz      = q[k].size();
      enqm[k] = !ack && !rd && (sz < mdepth[k] || (dr && sz > 0));
    end
    #2;
    for (int unsigned k = 0; k < NI; k++) begin
      if (!rn) begin
        q[k].delete();
        mfpc[k] = RPC;
      end else if (rd) begin
        q[k].delete();
        mfpc[k] = rpc;
      end else if (enqm[k]) begin
        q[k].push_back('{pc: mfpc[k], ir: wd});
        mfpc[k] = mfpc[k] + 32'd4;
      end
    end
    if (!rn) armed = 1'b1;
  endtask

  initial begin
    logic [31:0] rpc;
    rst_n = 1'b0; acki_n = 1'b1; deq_ready = 1'b0; redirect = 1'b0;
    redirect_pc = '0; idt = '0;

    // Reset
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Streaming with decode always ready
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0010_0093 + 32'(i) * 32'h0010_0020);

    // Fill while decode stalls, then stream at full occupancy
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, $urandom);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, $urandom);

    // Redirect with a partly filled queue, deq_ready asserted
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0200, $urandom);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, $urandom);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0200, $urandom);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, $urandom);

    // Redirect held for several cycles; last target wins
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_1000, $urandom);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_2000, $urandom);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_3002, $urandom);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, $urandom);

    // Wait states 1,0,1,1,0 from an empty queue
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0000, $urandom);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, $urandom);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, $urandom);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, $urandom);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, $urandom);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, $urandom);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, $urandom);

    // Fetch address wrap around 2^32
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF4, $urandom);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, $urandom);

    // Randomised traffic with occasional redirects and one mid-stream reset
    for (int i = 0; i < 600; i++) begin
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      step((i == 300) ? 1'b0 : 1'b1,
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) != 0) || (i > 500 && i < 520),
           ($urandom_range(0, 24) == 0),
           rpc, $urandom);
    end

    // Drain and final state check
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check_state();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
